reg_bank_nr: RTL and testbench

//  Parametrised register bank and successor to the single 16-bit register. It holds

---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/reg_bank_rdport.sv | 36 +++
 rtl/reg_bank_nr.sv | 117 +++++++++++
 tb/tb_reg_bank_nr.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: FSM encoding and default geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_bank_pkg;

    localparam int RB_WIDTH = 16;
    localparam int RB_DEPTH = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rb_state_e;

endpackage

// File: rtl/reg_bank_rdport.sv
// One read port: DEPTH:1 mux over the storage, entry-0 masking, optional write-through.
// Latency: combinational, zero cycles from address to data.
// Backpressure: none; the read is always available. Forwarding only with REG_BANK_BYPASS_EN.
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int WIDTH    = RB_WIDTH,
    parameter int DEPTH    = RB_DEPTH,
    parameter int AW       = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
`ifdef REG_BANK_BYPASS_EN
    input  logic                        byp_vld_i,
    input  logic [AW-1:0]               byp_addr_i,
    input  logic [WIDTH-1:0]            byp_dat_i,
`endif
    input  logic [AW-1:0]               raddr_i,
    output logic [WIDTH-1:0]            q_o
);

    // Select the addressed entry, force entry 0 to zero, then apply forwarding.
    always_comb begin
        q_o = mem_i[raddr_i];
        if (ZERO_REG && (raddr_i == '0)) begin
            q_o = '0;
        end
`ifdef REG_BANK_BYPASS_EN
        // byp_vld_i is only set for accepted writes, so entry 0 under ZERO_REG never forwards.
        if (byp_vld_i && (byp_addr_i == raddr_i)) begin
            q_o = byp_dat_i;
        end
`endif
    end

endmodule

// File: rtl/reg_bank_nr.sv
// Register file: DEPTH x WIDTH, one write port, two read ports, sequenced bulk clear.
// Latency: reads are combinational; writes visible the cycle after the edge (same cycle with REG_BANK_BYPASS_EN).
// Backpressure: busy is high for DEPTH cycles during a clear; writes then are dropped, not queued.
module reg_bank_nr
    import reg_bank_pkg::*;
#(
    parameter int             WIDTH    = RB_WIDTH,
    parameter int             DEPTH    = RB_DEPTH,
    parameter int             AW       = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter bit             ZERO_REG = 1'b1
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             write,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] Q_a,
    output logic [WIDTH-1:0] Q_b,
    input  logic             clr,
    output logic             busy
);

    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
    // Entry 0 holds zero under ZERO_REG so the storage never disagrees with the read masking.
    localparam logic [WIDTH-1:0] ENTRY0_INIT = ZERO_REG ? '0 : INIT_VAL;

    rb_state_e                    state_q;
    logic [AW-1:0]                cnt_q;
    logic                         busy_q;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q;
    logic                         wr_acc;

    assign wr_acc = write && !busy_q && (state_q == ST_IDLE)
                    && !(ZERO_REG && (waddr == '0));
    assign busy   = busy_q;

    // Clear sequencer: one entry per cycle, busy registered alongside the state.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // clr is ignored here; the sweep always runs to the last entry.
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: async load of INIT_VAL, then either the clear sweep or an accepted write.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == 0) ? ENTRY0_INIT : INIT_VAL;
            end
        end else if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= (cnt_q == '0) ? ENTRY0_INIT : INIT_VAL;
        end else if (wr_acc) begin
            // A write coinciding with clr in IDLE lands here and is swept over later.
            mem_q[waddr] <= D;
        end
    end

    reg_bank_rdport #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_rdport_a (
        .mem_i      (mem_q),
`ifdef REG_BANK_BYPASS_EN
        .byp_vld_i  (wr_acc),
        .byp_addr_i (waddr),
        .byp_dat_i  (D),
`endif
        .raddr_i    (raddr_a),
        .q_o        (Q_a)
    );

    reg_bank_rdport #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_rdport_b (
        .mem_i      (mem_q),
`ifdef REG_BANK_BYPASS_EN
        .byp_vld_i  (wr_acc),
        .byp_addr_i (waddr),
        .byp_dat_i  (D),
`endif
        .raddr_i    (raddr_b),
        .q_o        (Q_b)
    );

endmodule

// File: tb/tb_reg_bank_nr.sv
// Directed bench for reg_bank_nr: two instances (ZERO_REG=0 and ZERO_REG=1) on shared stimulus.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: exercises dropped writes while busy and the DEPTH-cycle busy window.
module tb_reg_bank_nr;

    localparam logic [15:0] IV = 16'hBEEF;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        write;
    logic [3:0]  waddr;
    logic [15:0] D;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;
    logic        clr;
    logic [15:0] qa0, qb0, qa1, qb1;
    logic        busy0, busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    reg_bank_nr #(.WIDTH(16), .DEPTH(16), .AW(4), .INIT_VAL(IV), .ZERO_REG(1'b0)) dut0 (
        .CLK(CLK), .reset_n(reset_n), .write(write), .waddr(waddr), .D(D),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .Q_a(qa0), .Q_b(qb0),
        .clr(clr), .busy(busy0)
    );

    reg_bank_nr #(.WIDTH(16), .DEPTH(16), .AW(4), .INIT_VAL(IV), .ZERO_REG(1'b1)) dut1 (
        .CLK(CLK), .reset_n(reset_n), .write(write), .waddr(waddr), .D(D),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .Q_a(qa1), .Q_b(qb1),
        .clr(clr), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] exp_byp;

        reset_n = 1'b0; write = 1'b0; waddr = '0; D = '0;
        raddr_a = 4'd3; raddr_b = 4'd0; clr = 1'b0;
        #12;
        // Reset state, observed while reset is still asserted.
        chk("rst_busy0", {15'd0, busy0}, 16'd0);
        chk("rst_busy1", {15'd0, busy1}, 16'd0);
        chk("rst_qa0",   qa0, IV);
        chk("rst_qb1_e0", qb1, 16'h0000);
        reset_n = 1'b1;
        tick();

        // 1. Every entry reads INIT_VAL on both ports (entry 0 zero under ZERO_REG).
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i);
            raddr_b = 4'(15 - i);
            #1;
            chk("init_qa0", qa0, IV);
            chk("init_qb0", qb0, IV);
            chk("init_qa1", qa1, (i == 0) ? 16'h0000 : IV);
            chk("init_qb1", qb1, (i == 15) ? 16'h0000 : IV);
        end

        // 2. Write 69 to entry 3, then an idle cycle with different D leaves it intact.
        write = 1'b1; waddr = 4'd3; D = 16'd69; raddr_a = 4'd3; raddr_b = 4'd3;
        tick();
        write = 1'b0; D = 16'd420;
        #1;
        chk("wr3_qa0", qa0, 16'd69);
        chk("wr3_qb1", qb1, 16'd69);
        tick();
        chk("hold3_qa0", qa0, 16'd69);
        chk("hold3_qa1", qa1, 16'd69);

        // 3. Entry 0: dropped under ZERO_REG, kept otherwise; entry 5 normal on both.
        write = 1'b1; waddr = 4'd0; D = 16'h1234; raddr_a = 4'd0;
        tick();
        write = 1'b0;
        #1;
        chk("e0_qa0", qa0, 16'h1234);
        chk("e0_qa1", qa1, 16'h0000);
        write = 1'b1; waddr = 4'd5; D = 16'h5555; raddr_b = 4'd5;
        tick();
        write = 1'b0;
        #1;
        chk("e5_qb0", qb0, 16'h5555);
        chk("e5_qb1", qb1, 16'h5555);

        // 4. Fill entries with their address, then clear with a write in the clr cycle.
        for (int i = 0; i < 16; i++) begin
            write = 1'b1; waddr = 4'(i); D = 16'(i);
            tick();
        end
        write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i);
            #1;
            chk("fill_qa0", qa0, 16'(i));
            chk("fill_qa1", qa1, (i == 0) ? 16'h0000 : 16'(i));
        end
        raddr_a = 4'd7; raddr_b = 4'd2;
        clr = 1'b1; write = 1'b1; waddr = 4'd2; D = 16'h2222;
        tick();
        clr = 1'b0; write = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("clr_busy0", {15'd0, busy0}, 16'd1);
            chk("clr_busy1", {15'd0, busy1}, 16'd1);
            if (k == 1) chk("clr_wr2_before", qb0, 16'h2222);
            if (k == 5) begin
                chk("clr_drop7", qa0, 16'd7);
                chk("clr_mix2", qb0, IV);
            end
            write = (k == 4);
            waddr = 4'd7; D = 16'h7777;
            clr = (k == 10);
            tick();
        end
        write = 1'b0; clr = 1'b0;
        #1;
        chk("clr_done_busy0", {15'd0, busy0}, 16'd0);
        chk("clr_done_busy1", {15'd0, busy1}, 16'd0);
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i);
            #1;
            chk("clr_all_qa0", qa0, IV);
            chk("clr_all_qa1", qa1, (i == 0) ? 16'h0000 : IV);
        end

        // 5. Reset six cycles into a clear returns everything to INIT_VAL at once.
        write = 1'b1; waddr = 4'd10; D = 16'h1010; raddr_a = 4'd10;
        tick();
        write = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (6) tick();
        chk("mid_busy0", {15'd0, busy0}, 16'd1);
        chk("mid_e10", qa0, 16'h1010);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy0", {15'd0, busy0}, 16'd0);
        chk("mid_rst_busy1", {15'd0, busy1}, 16'd0);
        chk("mid_rst_e10", qa0, IV);
        reset_n = 1'b1;
        tick();
        write = 1'b1; waddr = 4'd10; D = 16'h4321;
        tick();
        write = 1'b0;
        #1;
        chk("post_rst_wr0", qa0, 16'h4321);
        chk("post_rst_wr1", qa1, 16'h4321);

        // 6. Same-cycle read of the write address: forwarded only with the bypass build.
        raddr_b = 4'd9; write = 1'b1; waddr = 4'd9; D = 16'hA5A5;
`ifdef REG_BANK_BYPASS_EN
        exp_byp = 16'hA5A5;
`else
        exp_byp = IV;
`endif
        #1;
        chk("byp_qb0", qb0, exp_byp);
        chk("byp_qb1", qb1, exp_byp);
        tick();
        write = 1'b0;
        #1;
        chk("byp_after_qb0", qb0, 16'hA5A5);
        chk("byp_after_qb1", qb1, 16'hA5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
